// File: rtl/iss_select_arbiter_if.sv
// Issue-select handshake bundle: IQ/LSQ requests in, issue slot and pops out.
interface iss_select_arbiter_if #(
  parameter int IQ_ENTRIES = 16,
  parameter int IDX_BITS   = 4
);
  logic [IQ_ENTRIES-1:0] IQ_req_IN;
  logic                  LSQ_req_IN;
  logic                  EX_ready_IN;
  logic                  ISS_valid_OUT;
  logic                  ISS_mem_OUT;
  logic [IDX_BITS-1:0]   ISS_iqIdx_OUT;
  logic                  IQ_pop_OUT;
  logic                  LSQ_pop_OUT;

  modport master (
    input  IQ_req_IN,
    input  LSQ_req_IN,
    input  EX_ready_IN,
    output ISS_valid_OUT,
    output ISS_mem_OUT,
    output ISS_iqIdx_OUT,
    output IQ_pop_OUT,
    output LSQ_pop_OUT
  );

  modport slave (
    output IQ_req_IN,
    output LSQ_req_IN,
    output EX_ready_IN,
    input  ISS_valid_OUT,
    input  ISS_mem_OUT,
    input  ISS_iqIdx_OUT,
    input  IQ_pop_OUT,
    input  LSQ_pop_OUT
  );
endinterface

// File: rtl/iss_select_arbiter.sv
// Issue-select: oldest-ready IQ entry vs LSQ head, alternating on contention,
// registered into one output slot with one-shot pop strobes back to the queues.
module iss_select_arbiter #(
  parameter int IQ_ENTRIES = 16,
  parameter int IDX_BITS   = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic FREEZE,
  input  logic FLUSH_IN,
  iss_select_arbiter_if.master issIf
);

  logic                  validQ;
  logic                  memQ;
  logic [IDX_BITS-1:0]   idxQ;
  logic                  iqPopQ;
  logic                  lsqPopQ;
  logic                  prQ;

  logic                  iqPop;
  logic                  lsqPop;
  logic [IQ_ENTRIES-1:0] iqMask;
  logic                  iqAny;
  logic                  lsqAny;
  logic [IDX_BITS-1:0]   cand;
  logic [IDX_BITS-1:0]   candFix;
  logic                  found;
  logic                  free;
  logic                  both;
  logic                  winIq;
  logic                  winLsq;

  assign iqPop  = iqPopQ & ~FREEZE;
  assign lsqPop = lsqPopQ & ~FREEZE;

  assign issIf.ISS_valid_OUT = validQ;
  assign issIf.ISS_mem_OUT   = memQ;
  assign issIf.ISS_iqIdx_OUT = idxQ;
  assign issIf.IQ_pop_OUT    = iqPop;
  assign issIf.LSQ_pop_OUT   = lsqPop;

  // The popped entry still requests this cycle, so hide it from selection
  always_comb begin
    iqMask = issIf.IQ_req_IN;
    if (iqPop) iqMask[idxQ] = 1'b0;
  end

  always_comb begin
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < IQ_ENTRIES; i++) begin
      if (iqMask[i] && !found) begin
        cand  = IDX_BITS'(i);
        found = 1'b1;
      end
    end
  end

  // Entries above a popped one shift down by one as the IQ compresses
  assign candFix = (iqPop && cand > idxQ) ? cand - 1'b1 : cand;

  assign iqAny  = |iqMask;
  assign lsqAny = issIf.LSQ_req_IN & ~lsqPop;
  assign free   = ~validQ | issIf.EX_ready_IN;
  assign both   = iqAny & lsqAny;
  assign winIq  = iqAny & (~lsqAny | ~prQ);
  assign winLsq = lsqAny & (~iqAny | prQ);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      validQ  <= 1'b0;
      memQ    <= 1'b0;
      idxQ    <= '0;
      iqPopQ  <= 1'b0;
      lsqPopQ <= 1'b0;
      prQ     <= 1'b0;
    end else if (FREEZE) begin
      validQ  <= validQ;
    end else if (FLUSH_IN) begin
      validQ  <= 1'b0;
      iqPopQ  <= 1'b0;
      lsqPopQ <= 1'b0;
    end else if (free) begin
      unique case (1'b1)
        winIq: begin
          validQ  <= 1'b1;
          memQ    <= 1'b0;
          idxQ    <= candFix;
          iqPopQ  <= 1'b1;
          lsqPopQ <= 1'b0;
        end
        winLsq: begin
          validQ  <= 1'b1;
          memQ    <= 1'b1;
          iqPopQ  <= 1'b0;
          lsqPopQ <= 1'b1;
        end
        default: begin
          validQ  <= 1'b0;
          iqPopQ  <= 1'b0;
          lsqPopQ <= 1'b0;
        end
      endcase
      if (both) prQ <= ~prQ;
    end else begin
      iqPopQ  <= 1'b0;
      lsqPopQ <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iss_select_arbiter.sv
// Directed scoreboard bench for iss_select_arbiter.
module tb_iss_select_arbiter;

  logic CLK;
  logic RESET;
  logic FREEZE;
  logic FLUSH_IN;

  iss_select_arbiter_if #(.IQ_ENTRIES(16), .IDX_BITS(4)) issIf ();

  iss_select_arbiter #(.IQ_ENTRIES(16), .IDX_BITS(4)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .FREEZE   (FREEZE),
    .FLUSH_IN (FLUSH_IN),
    .issIf    (issIf)
  );

  typedef struct {
    logic       v;
    logic       m;
    logic [3:0] i;
    logic       ip;
    logic       lp;
    string      nm;
  } exp_t;

  exp_t expQ[$];
  int   tests  = 0;
  int   failed = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs for a cycle go in just after its rising edge; the expectation
  // describes the outputs seen during that same cycle.
  task automatic step(input logic rst, input logic frz, input logic fl,
                      input logic [15:0] iq, input logic lsq,
                      input logic ex, input logic v, input logic m,
                      input logic [3:0] i, input logic ip,
                      input logic lp, input string nm);
    exp_t e;
    @(posedge CLK);
    #1;
    RESET             = rst;
    FREEZE            = frz;
    FLUSH_IN          = fl;
    issIf.IQ_req_IN   = iq;
    issIf.LSQ_req_IN  = lsq;
    issIf.EX_ready_IN = ex;
    e.v  = v;
    e.m  = m;
    e.i  = i;
    e.ip = ip;
    e.lp = lp;
    e.nm = nm;
    expQ.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        tests++;
        if (issIf.ISS_valid_OUT !== e.v || issIf.ISS_mem_OUT !== e.m ||
            issIf.ISS_iqIdx_OUT !== e.i || issIf.IQ_pop_OUT !== e.ip ||
            issIf.LSQ_pop_OUT !== e.lp) begin
          failed++;
          $display("FAIL %s: got v=%b m=%b idx=%0d iqPop=%b lsqPop=%b, want v=%b m=%b idx=%0d iqPop=%b lsqPop=%b",
                   e.nm, issIf.ISS_valid_OUT, issIf.ISS_mem_OUT,
                   issIf.ISS_iqIdx_OUT, issIf.IQ_pop_OUT,
                   issIf.LSQ_pop_OUT, e.v, e.m, e.i, e.ip, e.lp);
        end
      end
    end
  end

  initial begin : driver
    RESET             = 1'b0;
    FREEZE            = 1'b0;
    FLUSH_IN          = 1'b0;
    issIf.IQ_req_IN   = 16'($urandom);
    issIf.LSQ_req_IN  = 1'b1;
    issIf.EX_ready_IN = 1'b1;

    //   rst frz fl  iq       lsq ex   v  m  idx  ip lp
    step(0, 0, 0, 16'($urandom), 1, 1, 0, 0, 4'd0, 0, 0, "rst1");
    step(0, 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
         0, 0, 4'd0, 0, 0, "rst2");
    step(1, 0, 0, 16'h0000, 0, 1, 0, 0, 4'd0, 0, 0, "rstHold");
    step(1, 0, 0, 16'h0124, 0, 1, 0, 0, 4'd0, 0, 0, "idle");
    step(1, 0, 0, 16'h0124, 0, 1, 1, 0, 4'd2, 1, 0, "oldest");
    step(1, 0, 0, 16'h0001, 1, 1, 1, 0, 4'd4, 1, 0, "compress");
    step(1, 0, 0, 16'h0001, 1, 1, 1, 0, 4'd0, 1, 0, "alt1Iq");
    step(1, 0, 0, 16'h0001, 1, 1, 1, 1, 4'd0, 0, 1, "alt2Lsq");
    step(1, 0, 0, 16'h0001, 1, 1, 1, 0, 4'd0, 1, 0, "alt3Iq");
    step(1, 0, 0, 16'h0008, 0, 1, 1, 1, 4'd0, 0, 1, "alt4Lsq");
    step(1, 0, 0, 16'h0008, 0, 0, 1, 0, 4'd3, 1, 0, "bp1");
    step(1, 0, 0, 16'h0008, 0, 0, 1, 0, 4'd3, 0, 0, "bp2");
    step(1, 0, 0, 16'h0008, 0, 0, 1, 0, 4'd3, 0, 0, "bp3");
    step(1, 0, 0, 16'h0008, 0, 0, 1, 0, 4'd3, 0, 0, "bp4");
    step(1, 0, 0, 16'h0002, 1, 1, 1, 0, 4'd3, 0, 0, "bpRelease");
    step(1, 0, 0, 16'h0002, 1, 1, 1, 1, 4'd3, 0, 1, "prLsq");
    step(1, 0, 0, 16'h0006, 1, 1, 1, 0, 4'd1, 1, 0, "iqOnly");
    step(1, 1, 0, 16'h0006, 1, 1, 1, 0, 4'd1, 0, 0, "frz1");
    step(1, 1, 0, 16'h0006, 1, 1, 1, 0, 4'd1, 0, 0, "frz2");
    step(1, 1, 0, 16'h0006, 1, 1, 1, 0, 4'd1, 0, 0, "frz3");
    step(1, 0, 0, 16'h0006, 1, 1, 1, 0, 4'd1, 1, 0, "frzRelease");
    step(1, 1, 1, 16'h0006, 1, 0, 1, 1, 4'd1, 0, 0, "frzFlush");
    step(1, 0, 1, 16'h0006, 1, 0, 1, 1, 4'd1, 0, 1, "flushPop");
    step(1, 0, 0, 16'h0006, 1, 1, 0, 1, 4'd1, 0, 0, "flushed");
    step(1, 0, 0, 16'h0000, 0, 1, 1, 0, 4'd1, 1, 0, "prHeld");
    step(1, 0, 0, 16'h0000, 0, 1, 0, 0, 4'd1, 0, 0, "drain");
    step(1, 0, 0, 16'h0000, 0, 1, 0, 0, 4'd1, 0, 0, "idleEnd");

    repeat (3) @(negedge CLK);
    #1;
    tests++;
    if (expQ.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
